// File: rtl/fdiv_arbiter.sv
// fdiv_arbiter: round-robin sharing of one iterative FDIV unit among NREQ issue ports with latched operands, response by ID, flush and watchdog.
module fdiv_arbiter #(
    parameter int NREQ    = 2,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic              flush_i,
    input  logic [NREQ-1:0]   req_valid_i,
    output logic [NREQ-1:0]   req_ready_o,
    input  logic [NREQ*147-1:0] req_bundle_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [IDW-1:0]    rsp_id_o,
    output logic [31:0]       rsp_data_o,
    output logic              rsp_err_o,
    output logic              div_enable_o,
    output logic [31:0]       div_rs1_o,
    output logic [9:0]        div_rs1Exp_o,
    output logic [23:0]       div_rs1Sig_o,
    output logic [5:0]        div_rs1Class_o,
    output logic [31:0]       div_rs2_o,
    output logic [9:0]        div_rs2Exp_o,
    output logic [23:0]       div_rs2Sig_o,
    output logic [5:0]        div_rs2Class_o,
    output logic [2:0]        div_rm_o,
    input  logic              div_ready_i,
    input  logic [31:0]       div_result_i,
    output logic              busy_o,
    output logic              timeout_o
);
    localparam int BW = 147;
    localparam int PW = $clog2(NREQ);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [BW-1:0]   op_q, op_d;
    logic [31:0]     data_q, data_d;
    logic            err_q, err_d, to_q, to_d, drop_q, drop_d;
    logic [WW-1:0]   wd_q, wd_d;
    logic [NREQ-1:0] rot;
    logic [PW-1:0]   win;
    logic            found, accept, done;

    // Rotate valids so bit 0 is the RR pointer; first set bit wins.
    always_comb begin
        rot = NREQ'({req_valid_i, req_valid_i} >> ptr_q);
        win = '0;
        found = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                win = PW'((int'(ptr_q) + j) % NREQ);
            end
        end
    end

    assign req_ready_o = (state_q == IDLE && resetn_i && !flush_i && found) ? NREQ'(1) << win : '0;
    assign accept      = |req_ready_o;
    assign done        = div_ready_i || wd_q == WW'(TIMEOUT - 1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        op_d    = op_q;
        data_d  = data_q;
        err_d   = err_q;
        to_d    = to_q;
        drop_d  = drop_q;
        wd_d    = '0;
        case (state_q)
            IDLE: if (accept) begin
                op_d    = req_bundle_i[int'(win)*BW +: BW];
                id_d    = IDW'(win);
                ptr_d   = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
                state_d = ISSUE;
            end
            ISSUE: begin
                drop_d  = drop_q | flush_i;
                state_d = WAIT;
            end
            WAIT: begin
                drop_d = drop_q | flush_i;
                wd_d   = wd_q + 1'b1;
                if (done) begin
                    wd_d    = '0;
                    to_d    = to_q | !div_ready_i;
                    data_d  = drop_d ? data_q : (div_ready_i ? div_result_i : 32'h7FC0_0000);
                    err_d   = drop_d ? err_q : !div_ready_i;
                    state_d = drop_d ? IDLE : RESP;
                end
            end
            RESP: state_d = (flush_i || rsp_ready_i) ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE) drop_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            op_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            drop_q  <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            op_q    <= op_d;
            data_q  <= data_d;
            err_q   <= err_d;
            to_q    <= to_d;
            drop_q  <= drop_d;
            wd_q    <= wd_d;
        end
    end

    assign busy_o       = state_q != IDLE;
    assign div_enable_o = state_q == ISSUE;
    assign rsp_valid_o  = state_q == RESP;
    assign rsp_id_o     = id_q;
    assign rsp_data_o   = data_q;
    assign rsp_err_o    = err_q;
    assign timeout_o    = to_q;
    assign {div_rs1_o, div_rs1Exp_o, div_rs1Sig_o, div_rs1Class_o,
            div_rs2_o, div_rs2Exp_o, div_rs2Sig_o, div_rs2Class_o, div_rm_o} = op_q;
endmodule

// File: doc/fdiv_arbiter.md
Name: fdiv_arbiter

Overview:
- Shares one iterative FDIV unit among NREQ requesters (integer-pipe FP issue ports) using round-robin arbitration.
- Latches the winning operand bundle and holds it stable on the divider inputs for the whole operation.
- Issues a single-cycle divide enable, waits for the divider's ready pulse, then returns the result with the requester ID over a valid/ready response port.
- Provides flush and a watchdog timeout.

Parameters:
- NREQ, 2, number of requesters (2..4).
- IDW, 2, width of the requester ID on the response port.
- TIMEOUT, 64, maximum WAIT cycles before an op is declared hung.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- resetn_i  in  1  reset; synchronous, active-low.
- flush_i  in  1  discard the in-flight result and any pending response.
- req_valid_i  in  NREQ  per-requester request valid.
- req_ready_o  out  NREQ  one-hot grant; accept happens on valid&ready.
- req_bundle_i  in  NREQ*147  per requester, LSB first: rm[2:0], rs2Class[5:0], rs2Sig[23:0], rs2Exp[9:0], rs2[31:0], rs1Class[5:0], rs1Sig[23:0], rs1Exp[9:0], rs1[31:0].
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response accepted.
- rsp_id_o  out  IDW  index of the requester the response belongs to.
- rsp_data_o  out  32  quotient.
- rsp_err_o  out  1  response produced by timeout.
- div_enable_o  out  1  to divider divEnable.
- div_rs1_o/div_rs1Exp_o/div_rs1Sig_o/div_rs1Class_o  out  32/10/24/6  latched operand A fields.
- div_rs2_o/div_rs2Exp_o/div_rs2Sig_o/div_rs2Class_o  out  32/10/24/6  latched operand B fields.
- div_rm_o  out  3  latched rounding mode.
- div_ready_i  in  1  divider done pulse.
- div_result_i  in  32  divider output, valid while div_ready_i is high.
- busy_o  out  1  state != IDLE.
- timeout_o  out  1  sticky; set on timeout, cleared only by reset.

Behaviour:
- Reset (resetn_i=0 at a clock edge): state=IDLE. All outputs go to 0: req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o, div_enable_o, div_* operands, busy_o, timeout_o. RR pointer=0, watchdog=0. Reset asserted mid-operation abandons the op with no response.

- IDLE:
  - req_ready_o is combinationally one-hot on the first requester with req_valid_i high, searching from the RR pointer upward with wrap-around.
  - No requests means req_ready_o=0.
  - On accept: latch that requester's bundle into the div_* registers, latch ID, set RR pointer = (winner+1) mod NREQ, go to ISSUE.

- ISSUE: div_enable_o=1 for exactly this one cycle; go to WAIT. div_enable_o is never high in any other state.

- WAIT:
  - Watchdog increments each cycle.
  - On div_ready_i=1: capture div_result_i into rsp_data_o, set rsp_err_o=0, go to RESP. If the drop flag is set, go to IDLE instead with no response.
  - If the watchdog reaches TIMEOUT before ready: set rsp_data_o=0x7FC00000, rsp_err_o=1, timeout_o=1, go to RESP (or IDLE if drop is set).

- RESP: rsp_valid_o=1 with rsp_id_o, rsp_data_o and rsp_err_o held stable until rsp_ready_i=1. On that handshake go to IDLE. No new accept happens in the same cycle.

- Operand stability: div_* outputs change only on an accept in IDLE. They stay constant through ISSUE, WAIT and RESP.

- Latency: accept cycle T, enable at T+1. Response valid at the cycle after the divider ready pulse, or at T+2+TIMEOUT on timeout.

- flush_i:
  - In ISSUE or WAIT: sets the drop flag. The divider still runs to completion; the controller waits for div_ready_i or timeout, then returns to IDLE with no response.
  - In RESP: deassert rsp_valid_o and go to IDLE next cycle.
  - In IDLE: no effect, and no accept that cycle.
  - flush_i has priority over rsp_ready_i in the same cycle.
  - The drop flag clears on entry to IDLE.

- A div_ready_i pulse outside WAIT is ignored.
- Simultaneous requests: exactly one is granted. Losers keep req_valid_i asserted and are granted in a later IDLE visit. Starvation-free.

Test Plan:
- Single op: requester 0 sends rs1=0x40C00000 (6.0), rs2=0x40000000 (2.0), rm=0 to a real FDIV -> one div_enable_o pulse, then rsp_valid_o with rsp_id_o=0, rsp_data_o=0x40400000, rsp_err_o=0.
- Contention: both requesters valid continuously with distinct operands (1.0/4.0=0x3E800000 and 9.0/3.0=0x40400000) -> grants alternate 0,1,0,1. IDs match the data. No grant is issued while busy_o=1.
- Backpressure: hold rsp_ready_i=0 for 10 cycles -> rsp_valid_o, rsp_id_o and rsp_data_o stay stable. req_ready_o stays 0 until the handshake.
- Flush mid-WAIT: assert flush_i 5 cycles after the enable -> no rsp_valid_o for that op. The next request is not issued before div_ready_i arrives.
- Timeout: stub divider that never raises ready, TIMEOUT=64 -> rsp_data_o=0x7FC00000, rsp_err_o=1, timeout_o=1 and sticky.
- Reset mid-WAIT: drop resetn_i low for one cycle -> every output reads 0 the next cycle, and arbitration restarts at requester 0.
